// File: rtl/apb_module_pkg.sv
// Shared types and default sizes for the APB configuration-register slave.
package apb_module_pkg;

   localparam int unsigned ADDR_W_DEF   = 8;
   localparam int unsigned DATA_W_DEF   = 8;
   localparam int unsigned NUM_REGS_DEF = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_t;

   // Index width for a register file of n entries (at least one bit).
   function automatic int unsigned idx_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/apb_module_regfile.sv
// NUM_REGS x DATA_W register storage: synchronous write, combinational read,
// synchronous clear to zero.
module apb_module_regfile
   import apb_module_pkg::*;
#(
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned NUM_REGS = NUM_REGS_DEF,
   parameter int unsigned IDX_W    = idx_width(NUM_REGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [IDX_W-1:0]  widx,
   input  logic [DATA_W-1:0] wdata,
   input  logic [IDX_W-1:0]  ridx,
   output logic [DATA_W-1:0] rdata_c
);

   logic [DATA_W-1:0] mem [NUM_REGS];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[widx] <= wdata;
      end
   end

   // Indices past the last entry read as zero for non-power-of-two depths.
   always_comb begin
      rdata_c = '0;
      if (32'(ridx) < NUM_REGS) begin
         rdata_c = mem[ridx];
      end
   end

endmodule

// File: rtl/apb_module.sv
// APB slave with a byte-wide register file and no wait states.
// Optional APB_PRDATA_GATE_EN: prdata reads zero outside a held read access.
module apb_module
   import apb_module_pkg::*;
#(
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned NUM_REGS = NUM_REGS_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] pwdata,
   output logic [DATA_W-1:0] prdata,
   input  logic              pwrite,
   input  logic              psel,
   input  logic              penable
);

   localparam int unsigned IDX_W = idx_width(NUM_REGS);

   apb_state_t        state;
   logic              enter_access_c;
   logic              in_range_c;
   logic              we_c;
   logic [IDX_W-1:0]  idx_c;
   logic [DATA_W-1:0] rdata_c;

   // The transfer fires only on the edge that moves the FSM into ACCESS.
   assign enter_access_c = psel && penable && (state != ACCESS);
   assign in_range_c     = (32'(addr) < NUM_REGS);
   assign idx_c          = addr[IDX_W-1:0];
   assign we_c           = enter_access_c && pwrite && in_range_c;

   apb_module_regfile #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .IDX_W    (IDX_W)
   ) u_regfile (
      .clk     (clk),
      .reset   (reset),
      .we      (we_c),
      .widx    (idx_c),
      .wdata   (pwdata),
      .ridx    (idx_c),
      .rdata_c (rdata_c)
   );

`ifdef APB_PRDATA_GATE_EN
   // Direction captured on ACCESS entry; pwrite is ignored while held.
   logic access_rd;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         prdata    <= '0;
         access_rd <= 1'b0;
      end else begin
         if (!psel) begin
            state <= IDLE;
         end else if (penable) begin
            state <= ACCESS;
         end else begin
            state <= SETUP;
         end

         if (enter_access_c) begin
            access_rd <= !pwrite;
         end

         if (enter_access_c && !pwrite) begin
            prdata <= in_range_c ? rdata_c : '0;
         end else if (!(psel && penable && (state == ACCESS) && access_rd)) begin
            prdata <= '0;
         end
      end
   end
`else
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         prdata <= '0;
      end else begin
         if (!psel) begin
            state <= IDLE;
         end else if (penable) begin
            state <= ACCESS;
         end else begin
            state <= SETUP;
         end

         if (enter_access_c && !pwrite) begin
            prdata <= in_range_c ? rdata_c : '0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_apb_module.sv
// Directed self-checking bench for apb_module (default and APB_PRDATA_GATE_EN builds).
module tb_apb_module;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] addr;
   logic [7:0] pwdata;
   logic [7:0] prdata;
   logic       pwrite;
   logic       psel;
   logic       penable;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   apb_module dut (
      .clk     (clk),
      .reset   (reset),
      .addr    (addr),
      .pwdata  (pwdata),
      .prdata  (prdata),
      .pwrite  (pwrite),
      .psel    (psel),
      .penable (penable)
   );

   // Inputs change and outputs are sampled at the falling edge.
   task automatic apb_write(input logic [7:0] a, input logic [7:0] d, input int hold);
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; addr = a; pwdata = d;
      @(negedge clk);
      penable = 1'b1;
      repeat (hold) @(negedge clk);
      penable = 1'b0;
      @(negedge clk);
      psel = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [7:0] a, output logic [7:0] d);
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; addr = a;
      @(negedge clk);
      penable = 1'b1;
      @(negedge clk);
      d = prdata;
      penable = 1'b0;
      @(negedge clk);
      psel = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] d;
      reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; addr = '0; pwdata = '0;
      repeat (4) @(negedge clk);
      total++;
      if (prdata !== 8'h00) begin
         bad++; $display("FAIL reset_prdata got=%h exp=00", prdata);
      end
      reset = 1'b0;
      for (int i = 0; i < 16; i++) begin
         apb_read(8'(i), d);
         total++;
         if (d !== 8'h00) begin
            bad++; $display("FAIL reset_reg%0d got=%h exp=00", i, d);
         end
      end
   endtask

   task automatic test_basic();
      logic [7:0] d;
      apb_write(8'd6, 8'h04, 3);
      apb_read(8'd6, d);
      total++;
      if (d !== 8'h04) begin
         bad++; $display("FAIL basic_reg6 got=%h exp=04", d);
      end
      apb_read(8'd5, d);
      total++;
      if (d !== 8'h00) begin
         bad++; $display("FAIL basic_reg5 got=%h exp=00", d);
      end
      apb_read(8'd7, d);
      total++;
      if (d !== 8'h00) begin
         bad++; $display("FAIL basic_reg7 got=%h exp=00", d);
      end
   endtask

   // Read reg 6 and watch prdata after penable and psel drop.
   task automatic test_prdata_hold();
      logic [7:0] exp_after;
`ifdef APB_PRDATA_GATE_EN
      exp_after = 8'h00;
`else
      exp_after = 8'h04;
`endif
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; addr = 8'd6;
      @(negedge clk);
      penable = 1'b1;
      @(negedge clk);
      total++;
      if (prdata !== 8'h04) begin
         bad++; $display("FAIL hold_access got=%h exp=04", prdata);
      end
      addr = 8'd5;
      @(negedge clk);
      total++;
      if (prdata !== 8'h04) begin
         bad++; $display("FAIL hold_addr_change got=%h exp=04", prdata);
      end
      penable = 1'b0;
      @(negedge clk);
      total++;
      if (prdata !== exp_after) begin
         bad++; $display("FAIL hold_after_penable got=%h exp=%h", prdata, exp_after);
      end
      psel = 1'b0;
      @(negedge clk);
      total++;
      if (prdata !== exp_after) begin
         bad++; $display("FAIL hold_after_psel got=%h exp=%h", prdata, exp_after);
      end
   endtask

   task automatic test_single_action();
      logic [7:0] d;
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; addr = 8'd2; pwdata = 8'hA5;
      @(negedge clk);
      penable = 1'b1;
      repeat (2) @(negedge clk);
      pwdata = 8'h11;
      repeat (3) @(negedge clk);
      penable = 1'b0;
      @(negedge clk);
      psel = 1'b0; pwrite = 1'b0;
      apb_read(8'd2, d);
      total++;
      if (d !== 8'hA5) begin
         bad++; $display("FAIL single_action_reg2 got=%h exp=a5", d);
      end
   endtask

   task automatic test_out_of_range();
      logic [7:0] d;
      apb_write(8'd200, 8'h77, 1);
      apb_read(8'd8, d);
      total++;
      if (d !== 8'h00) begin
         bad++; $display("FAIL oor_alias_reg8 got=%h exp=00", d);
      end
      apb_read(8'd6, d);
      total++;
      if (d !== 8'h04) begin
         bad++; $display("FAIL oor_reg6 got=%h exp=04", d);
      end
      apb_read(8'd200, d);
      total++;
      if (d !== 8'h00) begin
         bad++; $display("FAIL oor_read200 got=%h exp=00", d);
      end
   endtask

   // Setup and access collapsed into one sampled cycle.
   task automatic test_collapsed();
      logic [7:0] d;
      apb_read(8'd6, d);
      @(negedge clk);
      psel = 1'b1; penable = 1'b1; pwrite = 1'b0; addr = 8'd2;
      @(negedge clk);
      total++;
      if (prdata !== 8'hA5) begin
         bad++; $display("FAIL collapsed_read got=%h exp=a5", prdata);
      end
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic test_penable_no_psel();
      logic [7:0] d;
      @(negedge clk);
      psel = 1'b0; penable = 1'b1; pwrite = 1'b1; addr = 8'd3; pwdata = 8'h55;
      repeat (2) @(negedge clk);
      penable = 1'b0; pwrite = 1'b0;
      apb_read(8'd3, d);
      total++;
      if (d !== 8'h00) begin
         bad++; $display("FAIL no_psel_reg3 got=%h exp=00", d);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] d;
      apb_write(8'd1, 8'h3C, 1);
      apb_read(8'd1, d);
      total++;
      if (d !== 8'h3C) begin
         bad++; $display("FAIL mid_pre_reg1 got=%h exp=3c", d);
      end
      // Reset lands while a write to reg 9 is in its access phase.
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; addr = 8'd9; pwdata = 8'hEE;
      @(negedge clk);
      penable = 1'b1; reset = 1'b1;
      @(negedge clk);
      reset = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      total++;
      if (prdata !== 8'h00) begin
         bad++; $display("FAIL mid_prdata got=%h exp=00", prdata);
      end
      apb_read(8'd1, d);
      total++;
      if (d !== 8'h00) begin
         bad++; $display("FAIL mid_reg1 got=%h exp=00", d);
      end
      apb_read(8'd9, d);
      total++;
      if (d !== 8'h00) begin
         bad++; $display("FAIL mid_reg9 got=%h exp=00", d);
      end
      apb_read(8'd2, d);
      total++;
      if (d !== 8'h00) begin
         bad++; $display("FAIL mid_reg2 got=%h exp=00", d);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d;
      apb_write(8'd15, 8'hFF, 1);
      apb_write(8'd0, 8'h81, 1);
      apb_read(8'd15, d);
      total++;
      if (d !== 8'hFF) begin
         bad++; $display("FAIL b2b_reg15 got=%h exp=ff", d);
      end
      apb_read(8'd0, d);
      total++;
      if (d !== 8'h81) begin
         bad++; $display("FAIL b2b_reg0 got=%h exp=81", d);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_prdata_hold();
      test_single_action();
      test_out_of_range();
      test_collapsed();
      test_penable_no_psel();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/apb_module.md
Name: apb_module

Overview:
- APB-style slave holding a small byte-wide register file.
- Accepts single write and read transfers via psel/penable/pwrite; no wait states.
- Sits on a peripheral bus behind a bridge/master as a generic configuration-register block.
- No pready/pslverr ports: every transfer completes in its access phase.

Parameters:
- ADDR_W, 8: address width.
- DATA_W, 8: register and data bus width.
- NUM_REGS, 16: implemented registers, at addresses 0..NUM_REGS-1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset, sampled on rising clk.
- addr  in  ADDR_W  register address, valid while psel=1.
- pwdata  in  DATA_W  write data, valid while psel=1 and pwrite=1.
- prdata  out  DATA_W  registered read data.
- pwrite  in  1  1=write transfer, 0=read transfer.
- psel  in  1  slave select.
- penable  in  1  access-phase strobe.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - While reset=1 at a rising edge: all registers <= 0, prdata <= 0, FSM <= IDLE.
  - Reset has priority over any transfer. A reset mid-transfer aborts it with no write.
- FSM states:
  - IDLE: psel=0.
  - SETUP: psel=1, penable=0.
  - ACCESS: psel=1, penable=1.
- Transitions, evaluated each edge from the current psel/penable:
  - IDLE -> SETUP on psel&!penable.
  - IDLE -> ACCESS on psel&penable. Tolerant master: setup and access may collapse into one sampled cycle.
  - SETUP -> ACCESS on psel&penable; SETUP stays on psel&!penable.
  - ACCESS stays while psel&penable; ACCESS -> SETUP on psel&!penable.
  - Any state -> IDLE on !psel.
- Transfer action:
  - Occurs exactly once, on the edge that enters ACCESS.
  - Holding psel&penable high does not repeat the action.
  - Write (pwrite=1): reg[addr] <= pwdata when addr < NUM_REGS; other addresses are ignored.
  - Read (pwrite=0): prdata <= reg[addr] when addr < NUM_REGS, else prdata <= 0.
- Read latency: prdata is valid one clock after ACCESS is sampled and holds until the next read or reset.
- Signal changes during ACCESS: changes to addr, pwdata or pwrite while ACCESS is held have no effect.
- penable without psel: ignored.
- Width rules: addr compare is unsigned. Data is stored unmodified, full DATA_W.

Optional Feature:
- Macro: APB_PRDATA_GATE_EN.
- Defined: prdata is forced to 0 whenever the FSM is not in ACCESS with pwrite=0. This means a registered read value is visible only while the read access phase is held.
- Undefined: prdata holds the last read value indefinitely (default behaviour above).

Decomposition:
- Package apb_module_pkg:
  - FSM state enum: IDLE, SETUP, ACCESS.
  - Default width constants.
- One natural sub-module, apb_module_regfile: NUM_REGS x DATA_W storage with synchronous write enable, combinational read and synchronous reset-to-zero.
- FSM and prdata register stay in the top level.

Test Plan:
- Reset: hold reset=1 for 4 clks -> prdata=0; reading registers 0..15 each returns 0.
- Basic write/read:
  - Stimulus: write pwdata=4 to addr=6 (psel then penable, held ~3 clks, then drop penable, then psel).
  - Then read addr=6.
  - Required: prdata=4 one clk after ACCESS; addr 5 and addr 7 still read 0.
- Single-action check: write addr=2 data=0xA5 with penable held 5 clks while pwdata changes to 0x11 mid-ACCESS -> reg 2 reads 0xA5.
- Out-of-range: write 0x77 to addr=200 -> no register changes; read addr=200 -> prdata=0.
- Reset mid-operation: after writing 0x3C to addr=1, assert reset for 1 clk -> reading addr 1 returns 0.
- Macro build: with APB_PRDATA_GATE_EN, read addr=6 (holding 4) -> prdata=4 during ACCESS, and prdata=0 one clk after penable drops.
